// File: rtl/eight_div_module.sv
// Sequential restoring divider: one quotient bit per clock, one-cycle done pulse,
// results held in output registers until the next result is loaded.
module eight_div_module #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // One restoring step; pr is one bit wider than the divisor so the compare never overflows.
  logic [WIDTH:0]   pr_sh, pr_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             qbit;

  always_comb begin
    pr_sh  = {pr_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    qbit   = (pr_sh >= {1'b0, dvs_q});
    pr_nx  = qbit ? (pr_sh - {1'b0, dvs_q}) : pr_sh;
    quo_nx = {quo_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // DONE also accepts a start so back-to-back divisions lose no cycle.
        if (start) begin
          dvd_d = a;
          dvs_d = b;
          pr_d  = '0;
          quo_d = '0;
          cnt_d = '0;
          if (b != '0) begin
            state_d = CALC;
          end else begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = a;
            dbz_d       = 1'b1;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        pr_d  = pr_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          quotient_d  = quo_nx;
          remainder_d = pr_nx[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/eight_div_module.md
Name: eight_div_module

Overview:
- Sequential unsigned integer divider: the inverse operation to the team's combinational 8-bit multiplier in the Computation block set.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Started by a single-cycle `start` pulse; signals completion with a one-cycle `done` pulse.
- Results are held stable until the next accepted start.
- Used by the LCD computation path wherever a/b must be evaluated.

Parameters:
WIDTH, 8, operand/result width in bits; supported range 2..16; counter width is clog2(WIDTH).

Ports:
clk  input  1  single system clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled on rising edge; accepted only when busy=0
a  input  WIDTH  dividend (unsigned); sampled with accepted start
b  input  WIDTH  divisor (unsigned); sampled with accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid from this cycle on
quotient  output  WIDTH  a / b (unsigned, floor)
remainder  output  WIDTH  a % b
div_by_zero  output  1  set with done when b was 0; held with results

Behaviour:
- Reset: asserting rst_n=0 asynchronously forces the following, regardless of state, including mid-division:
  - state=IDLE, busy=0, done=0;
  - quotient=0, remainder=0, div_by_zero=0;
  - internal dividend, divisor, partial remainder and counter cleared.
- States: IDLE, CALC, DONE.
- IDLE: busy=0, done=0. On start=1:
  - latch a and b;
  - clear the (WIDTH+1)-bit partial remainder;
  - count=0;
  - if b≠0, go to CALC; if b==0, go to DONE.
- CALC: busy=1. Each edge performs one step:
  - pr = {pr[WIDTH-1:0], dvd[WIDTH-1]}; dvd shifted left by 1;
  - if pr ≥ {1'b0, divisor}: pr = pr − divisor and shift 1 into the quotient LSB; else shift in 0;
  - count += 1.
  - After the step with count==WIDTH-1, go to DONE.
  - Exactly WIDTH CALC cycles.
- DONE: busy=0, done=1 for exactly one cycle.
  - On entry, quotient/remainder/div_by_zero outputs are loaded: remainder = pr[WIDTH-1:0].
  - Next edge goes to IDLE, or directly re-enters CALC/DONE if start=1 (a back-to-back start is accepted in DONE).
- Latency, start sampled at edge N:
  - b≠0: done high in the cycle after edge N+WIDTH (N+8 for WIDTH=8); busy high in cycles after edges N..N+WIDTH-1.
  - b==0: done high in the cycle after edge N; busy never rises.
- Divide by zero: quotient = all ones (8'hFF), remainder = a, div_by_zero = 1.
- div_by_zero clears when the next result is loaded.
- start while busy=1 is ignored: no effect on the operation, operands or outputs.
- a and b may change freely except at the accepting edge.
- Output registers are written only on entry to DONE. They hold their value through IDLE and through the next CALC, so the previous result stays readable.
- Partial remainder is WIDTH+1 bits so the compare/subtract never overflows, e.g. a=255, b=255.
- Invariant for b≠0: quotient*b + remainder == a, and remainder < b.

Test Plan:
1. Reset, then a=200, b=7, start pulse at edge 0 -> busy high 8 cycles; done high for one cycle after edge 8; quotient=28, remainder=4, div_by_zero=0.
2. a=255, b=1 -> quotient=255, remainder=0. Then a=255, b=255 -> quotient=1, remainder=0. Then a=5, b=9 -> quotient=0, remainder=5.
3. a=77, b=0 -> done in the cycle after the accepting edge, busy stays 0; quotient=8'hFF, remainder=77, div_by_zero=1. A following 10/3 -> div_by_zero clears, quotient=3, remainder=1.
4. Start (100/9) accepted; start re-pulsed with a=1, b=1 at edge 3 -> ignored; result quotient=11, remainder=1 at the original latency. Start held high during the DONE cycle with 50/5 -> second division begins immediately; quotient=10, remainder=0 eight cycles later.
5. Drop rst_n mid-CALC (edge 4 of 200/7) -> outputs and busy go to 0 asynchronously, before the next clock edge; after release, a fresh 9/2 yields quotient=4, remainder=1 with normal latency.
6. Random sweep, 2000 pairs -> check quotient*b + remainder == a, remainder < b, and done exactly once per accepted start.
